// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control decoder and the multiply/divide sequencer.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} md_state_e;

  // Values match funct[1:0] of the corresponding MD instruction.
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

endpackage

// File: rtl/alu_control_md_muldiv_seq.sv
// Iterative multiply (shift-add) / restoring divide on operand magnitudes,
// with a final sign-fix cycle that presents the HI/LO write.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             wr
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  md_state_e          state_q, state_d;
  md_op_e             op_e;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mb_q, a_q;
  logic               neg_q, nrem_q, div_q;

  logic               accept, signed_op, sa, sb, last;
  logic [WIDTH-1:0]   mag_a, mag_b, q, r;
  logic [WIDTH:0]     msum, rsh, dif;
  logic [2*WIDTH-1:0] prod;

  assign op_e      = md_op_e'(op);
  assign signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign sa        = signed_op & a[WIDTH-1];
  assign sb        = signed_op & b[WIDTH-1];
  assign mag_a     = sa ? -a : a;
  assign mag_b     = sb ? -b : b;
  assign accept    = go && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last      = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = (op_e inside {MD_DIV, MD_DIVU}) ? ST_DIV : ST_MUL;
        else        state_d = ST_IDLE;
      end
      ST_MUL, ST_DIV: if (last) state_d = ST_FIX;
      ST_FIX:         state_d = ST_DONE;
      default:        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
    done = (state_q == ST_DONE);
    wr   = (state_q == ST_FIX);
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mb_q : '0)};
  assign rsh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign dif  = rsh - {1'b0, mb_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      mb_q   <= '0;
      a_q    <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      nrem_q <= 1'b0;
      div_q  <= 1'b0;
    end else if (accept) begin
      acc_q  <= {{WIDTH{1'b0}}, mag_a};
      mb_q   <= mag_b;
      a_q    <= a;
      cnt_q  <= '0;
      neg_q  <= sa ^ sb;
      nrem_q <= sa;
      div_q  <= (op_e inside {MD_DIV, MD_DIVU});
    end else if (state_q == ST_MUL || state_q == ST_DIV) begin
      cnt_q <= last ? '0 : cnt_q + CW'(1);
      if (state_q == ST_MUL)
        acc_q <= {msum, acc_q[WIDTH-1:1]};
      else if (dif[WIDTH])
        acc_q <= {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else
        acc_q <= {dif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // Divide by zero bypasses the sign fix: LO all ones, HI the original dividend.
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    q    = acc_q[WIDTH-1:0];
    r    = acc_q[2*WIDTH-1:WIDTH];
    if (!div_q) begin
      hi_out = prod[2*WIDTH-1:WIDTH];
      lo_out = prod[WIDTH-1:0];
    end else if (mb_q == '0) begin
      hi_out = a_q;
      lo_out = '1;
    end else begin
      hi_out = nrem_q ? -r : r;
      lo_out = neg_q ? -q : q;
    end
  end

endmodule

// File: rtl/alu_control_md.sv
// ALU control decoder with architectural HI/LO registers and an optional
// sequential multiply/divide unit.
module alu_control_md
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter bit          MD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic             start,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       ALUCtrl,
  output logic             illegal,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] md_result
);

  logic             fn_arith, fn_mthi, fn_mtlo, md_ok, go, wr;
  logic [WIDTH-1:0] hi_q, lo_q, hi_new, lo_new;

  always_comb begin
    ALUCtrl  = ALU_ADD;
    illegal  = 1'b0;
    fn_arith = 1'b0;
    fn_mthi  = 1'b0;
    fn_mtlo  = 1'b0;
    unique case (ALUOp)
      ALUOP_ADD:  ALUCtrl = ALU_ADD;
      ALUOP_SUB:  ALUCtrl = ALU_SUB;
      ALUOP_RSVD: illegal = 1'b1;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: ALUCtrl = ALU_ADD;
          FN_SUB, FN_SUBU: ALUCtrl = ALU_SUB;
          FN_AND:          ALUCtrl = ALU_AND;
          FN_OR:           ALUCtrl = ALU_OR;
          FN_XOR:          ALUCtrl = ALU_XOR;
          FN_NOR:          ALUCtrl = ALU_NOR;
          FN_SLT:          ALUCtrl = ALU_SLT;
          FN_SLTU:         ALUCtrl = ALU_SLTU;
          FN_SLL:          ALUCtrl = ALU_SLL;
          FN_SRL:          ALUCtrl = ALU_SRL;
          FN_SRA:          ALUCtrl = ALU_SRA;
          FN_MFHI, FN_MFLO: illegal = !MD_EN;
          FN_MTHI: begin
            illegal = !MD_EN;
            fn_mthi = 1'b1;
          end
          FN_MTLO: begin
            illegal = !MD_EN;
            fn_mtlo = 1'b1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            illegal  = !MD_EN;
            fn_arith = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  assign md_ok = start && (ALUOp == ALUOP_RTYPE) && !illegal && !md_busy;
  assign go    = md_ok && fn_arith;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wr) begin
      hi_q <= hi_new;
      lo_q <= lo_new;
    end else begin
      if (md_ok && fn_mthi) hi_q <= rs_val;
      if (md_ok && fn_mtlo) lo_q <= rs_val;
    end
  end

  assign md_result = (funct == FN_MFHI) ? hi_q : lo_q;

  if (MD_EN) begin : g_md
    muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .go     (go),
      .op     (funct[1:0]),
      .a      (rs_val),
      .b      (rt_val),
      .busy   (md_busy),
      .done   (md_done),
      .hi_out (hi_new),
      .lo_out (lo_new),
      .wr     (wr)
    );
  end else begin : g_no_md
    logic unused_md;
    assign unused_md = ^{go, rt_val};
    assign md_busy   = 1'b0;
    assign md_done   = 1'b0;
    assign wr        = 1'b0;
    assign hi_new    = '0;
    assign lo_new    = '0;
  end

endmodule

// File: doc/alu_control_md.md
# alu_control_md

Parametrised successor to the ALU control decoder for the multi-cycle MIPS core.
- Combinationally decodes ALUOp/funct into ALUCtrl over an extended op set: XOR, NOR, SLTU, shifts.
- Adds a sequential multiply/divide unit with architectural HI/LO registers, driven by the main control FSM in its execute state.
- Main control stalls on md_busy.

## Interface
- WIDTH, 32, operand and HI/LO width (even, ≥8)
- MD_EN, 1, 1 = multiply/divide hardware present; 0 = MD functs decode as illegal and HI/LO tie to 0
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ALUOp  in  2  from main control: 00 add, 01 sub, 10 R-type, 11 reserved
- funct  in  6  instruction[5:0]
- start  in  1  one-cycle pulse from main control in R-type execute state
- rs_val, rt_val  in  WIDTH  register operands
- ALUCtrl  out  4  to ALU (combinational)
- illegal  out  1  unsupported funct/ALUOp (combinational)
- md_busy  out  1  multiply/divide in progress
- md_done  out  1  one-cycle completion pulse
- md_result  out  WIDTH  HI when funct=MFHI, otherwise LO (combinational mux on registers)

## Operation
- **ALUCtrl encodings:** AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SLTU 1000, SRA 1001, NOR 1100.
- **ALUOp decode:** 00 → ADD; 01 → SUB; 11 → ADD with illegal=1.
- **R-type functs:**
  - ALU ops: ADD/ADDU 10000x, SUB/SUBU 10001x, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011, SLL 000000, SRL 000010, SRA 000011.
  - MD ops: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. For these, ALUCtrl=ADD.
  - Any other funct → ALUCtrl=ADD, illegal=1. No X outputs ever.
- **FSM states:**
  - IDLE: accepts start with ALUOp=10.
  - MUL: shift-add, one bit per cycle.
  - DIV: restoring, one quotient bit per cycle.
  - FIX: sign correction and HI/LO write.
  - DONE: md_done=1; returns to IDLE.
- **MULT/MULTU:**
  - Operands are converted to magnitudes (signed only).
  - Iteration runs WIDTH cycles.
  - FIX negates the 2·WIDTH product when the operand signs differ.
  - {HI,LO} ← product.
- **DIV/DIVU:**
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - LO ← quotient, HI ← remainder.
  - Signed MIN / −1 → LO=MIN, HI=0.
  - Divide by zero: LO=all ones, HI=rs_val; same latency, no flag.
- **MTHI/MTLO:** the accepted start writes HI/LO from rs_val at the next edge. No busy, no md_done.
- **MFHI/MFLO:** no state change; main control reads md_result.
- **start handling:**
  - start while md_busy is ignored; HI/LO and iteration are unaffected.
  - start with a non-MD funct or illegal has no effect.
- Operands are latched at the accept edge; rs_val/rt_val may change afterwards.

## Timing
- **Reset values:** state=IDLE, HI=LO=0, md_busy=0, md_done=0, counter=0.
- Combinational outputs follow their inputs and registers at reset.
- **MULT/DIV latency:** start is sampled at edge E0.
  - md_busy=1 from E0 through E(WIDTH+1).
  - HI/LO are written at edge E(WIDTH+1).
  - md_done=1 for the single cycle after E(WIDTH+1), with md_busy=0 in that cycle.
  - Total: WIDTH+2 cycles from start to md_done.
- A new start is accepted in the md_done cycle, since the state is IDLE-equivalent for accept. HI/LO are already updated.
- md_result during busy reflects the old HI/LO; main control must not issue MFHI/MFLO until md_busy=0.
- **Mid-operation reset:** rst_n low asynchronously aborts the operation, clears HI/LO, and drops md_busy/md_done immediately.
- Iteration counter is $clog2(WIDTH)+1 bits and never wraps beyond WIDTH.

## Structure
- **Package alu_pkg:**
  - ALUCtrl localparams
  - funct codes (ALU and MD)
  - ALUOp codes
  - FSM state enum
  - MD op enum (MULT, MULTU, DIV, DIVU)
- **Sub-module muldiv_seq:**
  - Iterative datapath and FSM with magnitude conversion, counter, sign fix.
  - Ports: clk, rst_n, go, op, a, b, busy, done, hi_out, lo_out, wr.
- **Top level:** decode, HI/LO registers, MT write path and md_result mux. Generate-out muldiv_seq when MD_EN=0.

## Test plan
- ALUOp=10, sweep every listed funct plus 111111 → ALUCtrl matches encoding table; illegal=1 only for 111111; ALUOp=11 → ADD, illegal=1.
- MULT rs=−3 (0xFFFFFFFD), rt=7 → md_done 34 cycles after start; HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 → LO=14, HI=2; DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5; second start mid-operation ignored (result and latency unchanged).
- MTLO 0x1234 then MFLO → md_result=0x1234 next cycle, no md_busy; MFHI during a running MULT shows old HI.
- rst_n pulse at cycle 10 of a DIV → md_busy=0 and HI=LO=0 asynchronously; following MULT 6×7 completes normally with LO=42.
